// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Receive side of the UART serial line. Double-synchronises rx_line, detects
// the start-bit falling edge, samples every bit at its centre, checks the stop
// bit and presents each word with a one-cycle rx_valid strobe, or raises a
// one-cycle frame_err when the stop bit is sampled low.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit, the PARITY_ODD parameter and the parity_err
// output. Without the macro the frame is start + DATA_BITS + stop.
`timescale 1ns/1ps

module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD   = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  // Counter widths: clk_cnt runs 0..CLKS_PER_BIT-1, bit_cnt runs 0..DATA_BITS-1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  // Half a bit period after the edge is the centre of the start bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  // One full bit period after the previous centre is the next centre.
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;

  localparam logic PAR_ODD = (PARITY_ODD != 0);

  // Parity bit the transmitter should have sent for this word.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] word,
                                           input logic                 odd);
    expected_parity = (^word) ^ odd;
  endfunction
`endif

  // Synchroniser and edge-detect history.
  logic                 sync_meta_q;
  logic                 rx_s_q;
  logic                 rx_prev_q;

  // Receive FSM and datapath.
  logic [2:0]           state_q,     state_d;
  logic [CW-1:0]        clk_cnt_q,   clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;

  // Registered outputs.
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q,      busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q,   par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // Two-flop synchroniser on rx_line plus one history flop for edge detection;
  // all three reset high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      sync_meta_q <= rx_line;
      rx_s_q      <= sync_meta_q;
      rx_prev_q   <= rx_s_q;
    end
  end

  // Next-state logic for the receive FSM, counters, shift register and pulses.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Only a high-to-low transition arms the receiver, so a line held
        // low after a break cannot re-trigger until it has returned high.
        clk_cnt_d = CNT_ZERO;
        if (rx_prev_q && !rx_s_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = CNT_ZERO;
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = BIT_ZERO;
          end else begin
            // Line is high again at the start-bit centre: a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = CNT_ZERO;
          // LSB arrives first: shift in at the top so it ends in bit 0.
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = CNT_ZERO;
          par_bad_d = (rx_s_q != expected_parity(shift_q, PAR_ODD));
          state_d   = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
`endif

      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          // Returning to IDLE at the stop-bit centre leaves half a bit of
          // margin before a back-to-back start edge can arrive.
          clk_cnt_d = CNT_ZERO;
          state_d   = ST_IDLE;
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
          end else begin
            // Bad stop bit: flag it and keep the last good word.
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = CNT_ZERO;
        bit_cnt_d = BIT_ZERO;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= CNT_ZERO;
      bit_cnt_q   <= BIT_ZERO;
      shift_q     <= {DATA_BITS{1'b0}};
      rx_data_q   <= {DATA_BITS{1'b0}};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check result held from the parity-bit centre to the stop-bit centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed self-checking bench for uart_rx_sampler (CLKS_PER_BIT=16,
// DATA_BITS=8). Stimulus is driven on the falling clock edge and outputs are
// sampled on the falling edge just before the next drive. Latencies are
// counted from the falling edge that first drives the start bit low; the two
// synchroniser stages add 2 cycles ahead of the first rx_s low cycle.
`timescale 1ns/1ps

module tb_uart_rx_sampler;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 11;   // start + 8 data + parity + stop
  localparam int LAT = 171;  // 2 sync + 1 + 8 + 160
  localparam int GAP = 176;  // one full frame
`else
  localparam int NB  = 10;   // start + 8 data + stop
  localparam int LAT = 155;  // 2 sync + 1 + 8 + 144
  localparam int GAP = 160;  // one full frame
`endif

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total;
  int bad;
  int both_n;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_line  (rx_line),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one complete frame and record every output pulse seen during it.
  task automatic send_frame(input  logic [7:0] data,
                            input  logic       par_bit,
                            input  logic       stop_bit,
                            output int         vld_at,
                            output int         vld_n,
                            output int         ferr_n,
                            output int         perr_at,
                            output int         perr_n,
                            output logic [7:0] got);
    logic [10:0] bits;
    int k;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, par_bit, data, 1'b0};
`else
    bits = {par_bit, stop_bit, data, 1'b0};
`endif
    vld_at = -1; vld_n = 0; ferr_n = 0; perr_at = -1; perr_n = 0; got = 8'h00;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        k = b * CPB + c;
        if (rx_valid === 1'b1) begin
          if (vld_at < 0) vld_at = k;
          vld_n++;
          got = rx_data;
        end
        if (frame_err === 1'b1) ferr_n++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_n++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) begin
          if (perr_at < 0) perr_at = k;
          perr_n++;
        end
`endif
        rx_line = bits[b];
      end
    end
  endtask

  // Hold the line idle high for n cycles and count any pulses.
  task automatic idle(input int n, output int vld_n, output int ferr_n);
    vld_n = 0; ferr_n = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) vld_n++;
      if (frame_err === 1'b1) ferr_n++;
      rx_line = 1'b1;
    end
  endtask

  task automatic test_reset();
    int v, f;
    rst_n = 1'b0;
    rx_line = 1'b1;
    #3;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20, v, f);
    total++; if (v !== 0 || f !== 0) begin bad++; $display("FAIL reset_release_pulses: got vld=%0d ferr=%0d want 0 0", v, f); end
  endtask

  task automatic test_basic();
    int at, vn, fn, pat, pn, v, f;
    logic [7:0] got;
    send_frame(8'hA5, 1'b0, 1'b1, at, vn, fn, pat, pn, got);
    total++; if (at !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", at, LAT); end
    total++; if (vn !== 1) begin bad++; $display("FAIL basic_valid_width: got %0d want 1", vn); end
    total++; if (got !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", got); end
    total++; if (fn !== 0) begin bad++; $display("FAIL basic_frame_err: got %0d want 0", fn); end
    idle(8, v, f);
    total++; if (v !== 0 || f !== 0) begin bad++; $display("FAIL basic_tail: got vld=%0d ferr=%0d want 0 0", v, f); end
  endtask

  task automatic test_glitch();
    int rise, fall, v, f;
    rise = -1; fall = -1; v = 0; f = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && rise < 0) rise = k;
      if (busy === 1'b0 && rise >= 0 && fall < 0) fall = k;
      if (rx_valid === 1'b1) v++;
      if (frame_err === 1'b1) f++;
      rx_line = (k < 4) ? 1'b0 : 1'b1;
    end
    total++; if (rise !== 3) begin bad++; $display("FAIL glitch_busy_rise: got %0d want 3", rise); end
    total++; if (fall !== 11) begin bad++; $display("FAIL glitch_busy_fall: got %0d want 11", fall); end
    total++; if (v !== 0 || f !== 0) begin bad++; $display("FAIL glitch_pulses: got vld=%0d ferr=%0d want 0 0", v, f); end
  endtask

  task automatic test_framing();
    int at, vn, fn, pat, pn, v, f;
    logic [7:0] got;
    send_frame(8'h3C, 1'b0, 1'b1, at, vn, fn, pat, pn, got);
    total++; if (got !== 8'h3C || vn !== 1) begin bad++; $display("FAIL frame_first: got %h n=%0d want 3c n=1", got, vn); end
    send_frame(8'h81, 1'b0, 1'b0, at, vn, fn, pat, pn, got);
    total++; if (fn !== 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", fn); end
    total++; if (vn !== 0) begin bad++; $display("FAIL frame_err_valid: got %0d want 0", vn); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL frame_err_hold: got %h want 3c", rx_data); end
    idle(16, v, f);
    send_frame(8'h55, 1'b0, 1'b1, at, vn, fn, pat, pn, got);
    total++; if (got !== 8'h55 || vn !== 1 || fn !== 0) begin bad++; $display("FAIL frame_recover: got %h n=%0d ferr=%0d want 55 1 0", got, vn, fn); end
  endtask

  task automatic test_back_to_back();
    int at1, at2, vn1, vn2, fn, pat, pn, v, f;
    logic [7:0] got1, got2;
    send_frame(8'h00, 1'b0, 1'b1, at1, vn1, fn, pat, pn, got1);
    send_frame(8'hFF, 1'b0, 1'b1, at2, vn2, fn, pat, pn, got2);
    total++; if (got1 !== 8'h00 || vn1 !== 1) begin bad++; $display("FAIL b2b_first: got %h n=%0d want 00 1", got1, vn1); end
    total++; if (got2 !== 8'hFF || vn2 !== 1) begin bad++; $display("FAIL b2b_second: got %h n=%0d want ff 1", got2, vn2); end
    total++; if ((GAP + at2 - at1) !== GAP || at1 !== LAT) begin bad++; $display("FAIL b2b_spacing: got %0d (first at %0d) want %0d", GAP + at2 - at1, at1, GAP); end
    idle(8, v, f);
  endtask

  task automatic test_reset_mid();
    int at, vn, fn, pat, pn, v, f;
    logic [10:0] bits;
    logic [7:0] got;
    bits = {2'b10, 8'h5A, 1'b0};
    // Data bit 3 occupies frame bit index 4; stop half-way through it.
    v = 0; f = 0;
    for (int k = 0; k < 4 * CPB + 8; k++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) v++;
      if (frame_err === 1'b1) f++;
      rx_line = bits[k / CPB];
    end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL mid_pulses: got vld=%b ferr=%b want 0 0", rx_valid, frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(20, vn, fn);
    total++; if (v + vn !== 0 || f + fn !== 0) begin bad++; $display("FAIL mid_stray: got vld=%0d ferr=%0d want 0 0", v + vn, f + fn); end
    send_frame(8'hC3, 1'b0, 1'b1, at, vn, fn, pat, pn, got);
    total++; if (got !== 8'hC3 || vn !== 1 || fn !== 0) begin bad++; $display("FAIL mid_recover: got %h n=%0d ferr=%0d want c3 1 0", got, vn, fn); end
  endtask

  task automatic test_break();
    int at, vn, fn, pat, pn, v, f;
    logic [7:0] got;
    v = 0; f = 0;
    for (int k = 0; k < 3 * NB * CPB; k++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) v++;
      if (frame_err === 1'b1) f++;
      rx_line = 1'b0;
    end
    total++; if (f !== 1) begin bad++; $display("FAIL break_frame_err: got %0d want 1", f); end
    total++; if (v !== 0) begin bad++; $display("FAIL break_valid: got %0d want 0", v); end
    idle(20, v, f);
    send_frame(8'h96, 1'b0, 1'b1, at, vn, fn, pat, pn, got);
    total++; if (got !== 8'h96 || vn !== 1 || fn !== 0) begin bad++; $display("FAIL break_recover: got %h n=%0d ferr=%0d want 96 1 0", got, vn, fn); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int at, vn, fn, pat, pn, v, f;
    logic [7:0] got;
    send_frame(8'h07, 1'b1, 1'b1, at, vn, fn, pat, pn, got);
    total++; if (got !== 8'h07 || vn !== 1) begin bad++; $display("FAIL parity_good_valid: got %h n=%0d want 07 1", got, vn); end
    total++; if (pn !== 0) begin bad++; $display("FAIL parity_good_err: got %0d want 0", pn); end
    send_frame(8'h07, 1'b0, 1'b1, at, vn, fn, pat, pn, got);
    total++; if (got !== 8'h07 || vn !== 1) begin bad++; $display("FAIL parity_bad_valid: got %h n=%0d want 07 1", got, vn); end
    total++; if (pn !== 1 || pat !== LAT) begin bad++; $display("FAIL parity_bad_err: got n=%0d at=%0d want 1 at %0d", pn, pat, LAT); end
    idle(8, v, f);
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    both_n = 0;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    total++; if (both_n !== 0) begin bad++; $display("FAIL exclusive_pulses: got %0d want 0", both_n); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
